// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_pkg
//  Description : Shared constants for the countdown timer. These are the FSM
//                state codes and the default counter width. The up-counter
//                used for layer/neuron sequencing uses the same width.
//  Revision    : 1.0 - initial release
// ============================================================================
package countdown_timer_pkg;

   // Default counter width, shared with the sequencing up-counter
   localparam int c_DEFAULT_WIDTH = 5;

   // FSM state encoding
   localparam logic [0:0] c_STATE_IDLE = 1'b0;
   localparam logic [0:0] c_STATE_RUN  = 1'b1;

endpackage : countdown_timer_pkg
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable down-counter with a start/done handshake.
//
//                A controller pulses start with a cycle budget on load.
//                The counter then spends exactly load+1 enabled RUN cycles
//                before it signals terminal count. At terminal count, done
//                pulses for one cycle.
//
//                Optional build macro COUNTDOWN_AUTORELOAD_EN:
//                  - When defined, terminal count reloads the latched budget
//                    and the counter stays in RUN. This gives a periodic done
//                    pulse until the count is aborted.
//                  - When undefined, the counter is one-shot and returns to
//                    IDLE at terminal count.
//
//  Ports       : CLOCK   in   system clock, rising edge
//                resetn  in   asynchronous active-low reset
//                start   in   begin a count (sampled only in IDLE)
//                load    in   count budget, latched when start is accepted
//                en      in   count enable (effective only in RUN)
//                abort   in   cancel an active count (no done pulse)
//                out     out  remaining count (registered)
//                busy    out  high while in RUN (registered)
//                done    out  one-cycle terminal-count pulse (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = c_DEFAULT_WIDTH
) (
   input  logic             CLOCK,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] load,
   input  logic             en,
   input  logic             abort,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] c_ZERO = '0;
   localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_busy;
   logic             r_done;
`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [WIDTH-1:0] r_latched_load;
`endif

   always_ff @(posedge CLOCK or negedge resetn) begin
      if (!resetn) begin
         r_state        <= c_STATE_IDLE;
         r_count        <= c_ZERO;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
         r_latched_load <= c_ZERO;
`endif
      end else begin
         // done is a pulse. Only the terminal-count branch sets it.
         r_done <= 1'b0;
         case (r_state)
            c_STATE_IDLE: begin
               if (start) begin
                  r_count        <= load;
`ifdef COUNTDOWN_AUTORELOAD_EN
                  r_latched_load <= load;
`endif
                  r_busy         <= 1'b1;
                  r_state        <= c_STATE_RUN;
               end
            end
            c_STATE_RUN: begin
               // abort is checked first so that it outranks terminal count
               // and never produces a done pulse.
               if (abort) begin
                  r_count <= c_ZERO;
                  r_busy  <= 1'b0;
                  r_state <= c_STATE_IDLE;
               end else if (en) begin
                  if (r_count == c_ZERO) begin
                     // The terminal step is the enabled cycle spent at
                     // zero. This gives the load+1 period.
                     r_done <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     r_count <= r_latched_load;
`else
                     r_busy  <= 1'b0;
                     r_state <= c_STATE_IDLE;
`endif
                  end else begin
                     r_count <= r_count - c_ONE;
                  end
               end
            end
            default: begin
               r_state <= c_STATE_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign out  = r_count;
   assign busy = r_busy;
   assign done = r_done;

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer. The reference
//                model tracks how many enabled cycles have passed since
//                start, and derives the expected outputs from the budget.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

   localparam int c_W = 5;

   logic           CLOCK = 1'b0;
   logic           resetn;
   logic           start;
   logic [c_W-1:0] load;
   logic           en;
   logic           abort;
   logic [c_W-1:0] out;
   logic           busy;
   logic           done;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit m_active = 0;
   int m_load   = 0;
   int m_steps  = 0;   // enabled RUN cycles consumed since (re)load
   int m_out    = 0;
   bit m_done   = 0;

   countdown_timer #(.WIDTH(c_W)) dut (
      .CLOCK  (CLOCK),
      .resetn (resetn),
      .start  (start),
      .load   (load),
      .en     (en),
      .abort  (abort),
      .out    (out),
      .busy   (busy),
      .done   (done)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic model_reset();
      m_active = 0; m_load = 0; m_steps = 0; m_out = 0; m_done = 0;
   endtask

   // A run consumes load+1 enabled cycles. The remaining count is the
   // budget minus the steps taken so far.
   task automatic model_step();
      m_done = 0;
      if (!m_active) begin
         if (start) begin
            m_active = 1; m_load = int'(load); m_steps = 0; m_out = m_load;
         end
      end else if (abort) begin
         m_active = 0; m_out = 0;
      end else if (en) begin
         if (m_steps == m_load) begin
            m_done = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            m_steps = 0; m_out = m_load;
`else
            m_active = 0; m_out = 0;
`endif
         end else begin
            m_steps++;
            m_out = m_load - m_steps;
         end
      end
   endtask

   // Advance one clock with the current inputs, then settle past the edge
   task automatic tick();
      @(posedge CLOCK);
      model_step();
      #1;
   endtask

   task automatic drive(input bit s, input int l, input bit e, input bit a);
      start = s; load = c_W'(l); en = e; abort = a;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0);
      resetn = 1'b0;
      model_reset();
      repeat (2) @(posedge CLOCK);
      #1;
      n_cmp++;
      if ({out, busy, done} !== {5'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset: got out=%0d busy=%b done=%b, expected 0/0/0", out, busy, done);
      end
      resetn = 1'b1;
      tick();
      n_cmp++;
      if ({out, busy, done} !== {5'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_idle: got out=%0d busy=%b done=%b, expected 0/0/0", out, busy, done);
      end
   endtask

   task automatic test_basic();
      int seen_done = 0;
      drive(1, 3, 1, 0);
      tick();
      start = 0;
      for (int c = 0; c < 6; c++) begin
         n_cmp++;
         if ({out, busy, done} !== {c_W'(m_out), m_active, m_done}) begin
            n_err++;
            $display("FAIL basic c%0d: got out=%0d busy=%b done=%b, expected out=%0d busy=%b done=%b",
                     c, out, busy, done, m_out, m_active, m_done);
         end
         if (done) seen_done++;
         tick();
      end
      n_cmp++;
      if (seen_done != 1) begin
         n_err++;
         $display("FAIL basic_done_count: got %0d done pulses, expected 1", seen_done);
      end
   endtask

   task automatic test_en_toggle();
      bit pat [5] = '{1, 0, 1, 0, 1};
      drive(1, 2, 0, 0);
      tick();
      start = 0;
      for (int c = 0; c < 7; c++) begin
         en = (c < 5) ? pat[c] : 1'b0;
         n_cmp++;
         if ({out, busy, done} !== {c_W'(m_out), m_active, m_done}) begin
            n_err++;
            $display("FAIL en_toggle c%0d: got out=%0d busy=%b done=%b, expected out=%0d busy=%b done=%b",
                     c, out, busy, done, m_out, m_active, m_done);
         end
         tick();
      end
      n_cmp++;
      if ({out, busy, done} !== {c_W'(m_out), m_active, m_done}) begin
         n_err++;
         $display("FAIL en_toggle_end: got out=%0d busy=%b done=%b, expected out=%0d busy=%b done=%b",
                  out, busy, done, m_out, m_active, m_done);
      end
   endtask

   task automatic test_abort();
      bit saw_done = 0;
      drive(1, 5, 1, 0);
      tick();
      start = 0;
      for (int c = 0; c < 10 && m_active; c++) begin
         abort = (m_out == 3);
         if (done) saw_done = 1;
         tick();
      end
      abort = 0;
      n_cmp++;
      if ({out, busy, done} !== {5'd0, 1'b0, 1'b0} || m_active) begin
         n_err++;
         $display("FAIL abort: got out=%0d busy=%b done=%b, expected 0/0/0", out, busy, done);
      end
      tick();
      if (done) saw_done = 1;
      n_cmp++;
      if (saw_done) begin
         n_err++;
         $display("FAIL abort_no_done: got done pulse, expected none");
      end
   endtask

   task automatic test_back_to_back();
      int guard = 0;
      drive(1, 0, 1, 0);
      tick();
      start = 0;
      while (!m_done && guard < 8) begin
         tick();
         guard++;
      end
      n_cmp++;
      if (done !== 1'b1 || !m_done) begin
         n_err++;
         $display("FAIL b2b_first_done: got done=%b, expected 1 (model %b)", done, m_done);
      end
      drive(1, 1, 1, 0);
      tick();
      start = 0;
      n_cmp++;
      if ({out, busy, done} !== {c_W'(m_out), m_active, m_done}) begin
         n_err++;
         $display("FAIL b2b_restart: got out=%0d busy=%b done=%b, expected out=%0d busy=%b done=%b",
                  out, busy, done, m_out, m_active, m_done);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({out, busy, done} !== {c_W'(m_out), m_active, m_done}) begin
            n_err++;
            $display("FAIL b2b c%0d: got out=%0d busy=%b done=%b, expected out=%0d busy=%b done=%b",
                     c, out, busy, done, m_out, m_active, m_done);
         end
      end
      abort = 1; tick(); abort = 0;
   endtask

   task automatic test_async_reset();
      int guard = 0;
      drive(1, 7, 1, 0);
      tick();
      drive(0, 7, 1, 0);
      while (m_out != 4 && guard < 10) begin
         tick();
         guard++;
      end
      // start while running must not reload the counter
      drive(1, 20, 1, 0);
      tick();
      n_cmp++;
      if ({out, busy, done} !== {c_W'(m_out), m_active, m_done} || m_out != 3) begin
         n_err++;
         $display("FAIL start_in_run: got out=%0d busy=%b, expected out=%0d busy=%b",
                  out, busy, m_out, m_active);
      end
      start = 0;
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({out, busy, done} !== {5'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL async_reset: got out=%0d busy=%b done=%b, expected 0/0/0", out, busy, done);
      end
      @(posedge CLOCK);
      #1;
      resetn = 1'b1;
      tick();
   endtask

`ifdef COUNTDOWN_AUTORELOAD_EN
   task automatic test_autoreload();
      int pulses = 0;
      drive(1, 2, 1, 0);
      tick();
      start = 0;
      for (int c = 1; c <= 9; c++) begin
         n_cmp++;
         if ({out, busy, done} !== {c_W'(m_out), m_active, m_done} || busy !== 1'b1) begin
            n_err++;
            $display("FAIL autoreload c%0d: got out=%0d busy=%b done=%b, expected out=%0d busy=1 done=%b",
                     c, out, busy, done, m_out, m_done);
         end
         tick();
         if (done) pulses++;
      end
      n_cmp++;
      if (pulses != 3) begin
         n_err++;
         $display("FAIL autoreload_pulses: got %0d, expected 3", pulses);
      end
      abort = 1; tick(); abort = 0;
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         start = ($urandom_range(0, 3) == 0);
         load  = c_W'($urandom_range(0, 6));
         en    = ($urandom_range(0, 3) != 0);
         abort = ($urandom_range(0, 19) == 0);
         tick();
         n_cmp++;
         if ({out, busy, done} !== {c_W'(m_out), m_active, m_done}) begin
            n_err++;
            $display("FAIL random c%0d: got out=%0d busy=%b done=%b, expected out=%0d busy=%b done=%b",
                     c, out, busy, done, m_out, m_active, m_done);
         end
      end
      drive(0, 0, 0, 0);
   endtask

   initial begin
      resetn = 1'b0;
      drive(0, 0, 0, 0);
      test_reset();
      test_basic();
      test_en_toggle();
      test_abort();
      test_back_to_back();
      test_async_reset();
`ifdef COUNTDOWN_AUTORELOAD_EN
      test_autoreload();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_countdown_timer
`default_nettype wire
